// File: rtl/ps2_rx_if.sv
// PS/2 receiver read-side bus.
// The consumer drives rd_en; the receiver drives data and status.
interface ps2_rx_if;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rx_valid;
  logic        rx_overflow;
  logic        frame_err;

  modport master (
    output rd_en,
    input  rd_data,
    input  rx_valid,
    input  rx_overflow,
    input  frame_err
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rx_valid,
    output rx_overflow,
    output frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: sync, frame FSM with timeout,
// odd-parity check and a small received-byte FIFO.
module ps2_rx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  ps2_rx_if.slave  bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]  sc_q, sd_q;
  logic        prev_q;
  logic        fall, dbit;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        push;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic          ovf_q, ovf_d;
  logic          pop, full, wr_ok, ovf_new;

  assign fall = prev_q & ~sc_q[1];
  assign dbit = sd_q[1];

  // Two-flop synchronizers plus previous-clock flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q   <= 2'b11;
      sd_q   <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sc_q   <= {sc_q[0], ps2_clk};
      sd_q   <= {sd_q[0], ps2_data};
      prev_q <= sc_q[1];
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Frame FSM next state; a stalled frame is dropped by the timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (state_q == IDLE || fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (fall && !dbit) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {dbit, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = ^{shift_q, dbit};
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (dbit && par_q) begin
            push = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !fall &&
        tmo_q == TIMEOUT - 16'd1) begin
      state_d = IDLE;
      cnt_d   = '0;
      tmo_d   = '0;
      err_d   = 1'b1;
    end
  end

  // FIFO bookkeeping: pop first, so a full FIFO can accept a push
  always_comb begin
    pop     = bus.rd_en && (fcnt_q != '0);
    full    = (fcnt_q == FULL_C);
    wr_ok   = push && (!full || pop);
    ovf_new = push && full && !pop;
    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (wr_ok && !pop) begin
      fcnt_d = fcnt_q + CNT_ONE;
    end else if (pop && !wr_ok) begin
      fcnt_d = fcnt_q - CNT_ONE;
    end
    if (ovf_new) begin
      ovf_d = 1'b1;
    end else if (bus.rd_en) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO pointer, occupancy and overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  assign bus.rx_valid    = (fcnt_q != '0);
  assign bus.rd_data     = (fcnt_q != '0) ?
                           {8'h00, mem[rd_ptr_q]} : 16'h0000;
  assign bus.rx_overflow = ovf_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx with a queue-based
// reference model and randomized frame traffic.
module tb_ps2_rx;

  localparam int DEPTH = 4;
  localparam int TMO   = 200;
  localparam int H     = 8;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk;
  logic ps2_data;

  ps2_rx_if bus ();

  ps2_rx #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT(16'(TMO))
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  byte unsigned model_q[$];
  bit model_ovf;

  // count every cycle frame_err is high
  always @(negedge clk) begin
    if (!rst && bus.frame_err) err_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d",
             total, bad);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input bit pop_on_fall);
    ps2_data = b;
    cyc(H);
    ps2_clk = 1'b0;
    if (pop_on_fall) begin
      // two sync flops, then the edge cycle where the push lands
      cyc(2);
      bus.rd_en = 1'b1;
      cyc(1);
      bus.rd_en = 1'b0;
      cyc(H - 3);
    end else begin
      cyc(H);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input byte unsigned b, input bit bad_par,
                            input bit bad_stop, input bit pop_on_stop);
    bit p;
    p = ($countones(b) % 2 == 0);
    if (bad_par) p = !p;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(p, 1'b0);
    send_bit(!bad_stop, pop_on_stop);
    ps2_data = 1'b1;
    cyc(4);
  endtask

  function automatic void model_push(input byte unsigned b);
    if (model_q.size() >= DEPTH) model_ovf = 1'b1;
    else model_q.push_back(b);
  endfunction

  task automatic pulse_rd();
    bus.rd_en = 1'b1;
    cyc(1);
    bus.rd_en = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    model_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    bus.rd_en = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    bus.rd_en = 1'b0;
    cyc(3);
    total++;
    if (bus.rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b want 0", bus.rx_valid);
    end
    total++;
    if (bus.rd_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data: got %h want 0000", bus.rd_data);
    end
    total++;
    if (bus.rx_overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf: got %b want 0", bus.rx_overflow);
    end
    total++;
    if (bus.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: got %b want 0", bus.frame_err);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int e0;
    do_reset();
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    model_push(8'h1C);
    total++;
    if (bus.rx_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_valid: got %b want 1", bus.rx_valid);
    end
    total++;
    if (bus.rd_data !== 16'h001C) begin
      bad++;
      $display("FAIL basic_data: got %h want 001c", bus.rd_data);
    end
    pulse_rd();
    total++;
    if (bus.rx_valid !== 1'b0 || bus.rd_data !== 16'h0000) begin
      bad++;
      $display("FAIL basic_pop: got valid=%b data=%h want 0/0000",
               bus.rx_valid, bus.rd_data);
    end
    pulse_rd();
    total++;
    if (bus.rx_valid !== 1'b0 || bus.rd_data !== 16'h0000) begin
      bad++;
      $display("FAIL empty_pop: got valid=%b data=%h want 0/0000",
               bus.rx_valid, bus.rd_data);
    end
    total++;
    if (err_cnt - e0 !== 0) begin
      bad++;
      $display("FAIL basic_err: got %0d pulses want 0", err_cnt - e0);
    end
  endtask

  task automatic test_frame_errors();
    int e0;
    do_reset();
    e0 = err_cnt;
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    total++;
    if (err_cnt - e0 !== 1) begin
      bad++;
      $display("FAIL parity_err: got %0d pulses want 1", err_cnt - e0);
    end
    total++;
    if (bus.rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL parity_valid: got %b want 0", bus.rx_valid);
    end
    e0 = err_cnt;
    send_frame(8'h3A, 1'b0, 1'b1, 1'b0);
    total++;
    if (err_cnt - e0 !== 1 || bus.rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL stop_err: got %0d pulses valid=%b want 1/0",
               err_cnt - e0, bus.rx_valid);
    end
  endtask

  task automatic test_overflow();
    byte unsigned exp;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send_frame(byte'(8'h11 * i), 1'b0, 1'b0, 1'b0);
      model_push(byte'(8'h11 * i));
    end
    total++;
    if (bus.rx_overflow !== model_ovf || model_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got %b want 1", bus.rx_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      exp = byte'(8'h11 * (i + 1));
      total++;
      if (bus.rd_data !== {8'h00, exp}) begin
        bad++;
        $display("FAIL ovf_read%0d: got %h want %h",
                 i, bus.rd_data, {8'h00, exp});
      end
      pulse_rd();
      if (i == 0) begin
        total++;
        if (bus.rx_overflow !== 1'b0) begin
          bad++;
          $display("FAIL ovf_clear: got %b want 0", bus.rx_overflow);
        end
      end
    end
    total++;
    if (bus.rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_drain: got %b want 0", bus.rx_valid);
    end
  endtask

  task automatic test_timeout();
    int e0;
    do_reset();
    e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    cyc(TMO + 10);
    total++;
    if (err_cnt - e0 !== 1 || bus.rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_err: got %0d pulses valid=%b want 1/0",
               err_cnt - e0, bus.rx_valid);
    end
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.rd_data !== 16'h0029) begin
      bad++;
      $display("FAIL timeout_next: got %h want 0029", bus.rd_data);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    byte unsigned b;
    do_reset();
    e0 = err_cnt;
    b = 8'hA7;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    model_q.delete();
    model_ovf = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.rd_data !== 16'h005A) begin
      bad++;
      $display("FAIL rstmid_data: got %h want 005a", bus.rd_data);
    end
    pulse_rd();
    total++;
    if (bus.rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_only: got valid=%b want 0", bus.rx_valid);
    end
    total++;
    if (err_cnt - e0 !== 0) begin
      bad++;
      $display("FAIL rstmid_err: got %0d pulses want 0", err_cnt - e0);
    end
  endtask

  task automatic test_full_pop();
    byte unsigned b;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      b = byte'($urandom_range(0, 255));
      send_frame(b, 1'b0, 1'b0, 1'b0);
      model_push(b);
    end
    b = byte'($urandom_range(0, 255));
    send_frame(b, 1'b0, 1'b0, 1'b1);
    void'(model_q.pop_front());
    model_q.push_back(b);
    total++;
    if (bus.rx_overflow !== 1'b0) begin
      bad++;
      $display("FAIL fullpop_ovf: got %b want 0", bus.rx_overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (bus.rd_data !== {8'h00, model_q[0]}) begin
        bad++;
        $display("FAIL fullpop_read%0d: got %h want %h",
                 i, bus.rd_data, {8'h00, model_q[0]});
      end
      pulse_rd();
    end
    total++;
    if (bus.rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL fullpop_count: got valid=%b want 0", bus.rx_valid);
    end
  endtask

  task automatic test_random();
    int e0, exp_err, kind, nrd;
    byte unsigned b;
    do_reset();
    e0 = err_cnt;
    exp_err = 0;
    for (int n = 0; n < 16; n++) begin
      b = byte'($urandom_range(0, 255));
      kind = $urandom_range(0, 5);
      send_frame(b, kind == 4, kind == 5, 1'b0);
      if (kind >= 4) exp_err++;
      else model_push(b);
      total++;
      if (bus.rx_overflow !== model_ovf ||
          bus.rx_valid !== (model_q.size() != 0)) begin
        bad++;
        $display("FAIL rand_status%0d: got ovf=%b valid=%b want %b/%b",
                 n, bus.rx_overflow, bus.rx_valid, model_ovf,
                 model_q.size() != 0);
      end
      nrd = $urandom_range(0, 2);
      for (int r = 0; r < nrd; r++) begin
        total++;
        if (model_q.size() == 0) begin
          if (bus.rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL rand_read%0d: got %h want 0000",
                     n, bus.rd_data);
          end
        end else if (bus.rd_data !== {8'h00, model_q[0]}) begin
          bad++;
          $display("FAIL rand_read%0d: got %h want %h",
                   n, bus.rd_data, {8'h00, model_q[0]});
        end
        pulse_rd();
      end
    end
    total++;
    if (err_cnt - e0 !== exp_err) begin
      bad++;
      $display("FAIL rand_err: got %0d pulses want %0d",
               err_cnt - e0, exp_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    bus.rd_en = 1'b0;
    test_reset();
    test_basic();
    test_frame_errors();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_full_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: received-byte FIFO entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 16'd50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  system clock; all state SHALL be sampled on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 rd_en  input  1  memory-side read strobe; pops one FIFO entry per asserted cycle.
REQ-008 rd_data  output  16  {8'h00, head byte} when FIFO is non-empty, 16'h0000 when it is empty.
REQ-009 rx_valid  output  1  FIFO non-empty.
REQ-010 rx_overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-011 frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-013 Falling edge = synchronized ps2_clk previous 1, current 0; bits SHALL be sampled from synchronized ps2_data on that cycle only.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: edge with data 0 -> DATA, bit count 0; edge with data 1 -> stay IDLE, no error.
REQ-016 DATA: each edge shifts in one bit, LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: edge samples the parity bit; odd parity over 8 data bits + parity bit -> STOP.
REQ-018 STOP: edge with data 1 and parity good -> push byte, go IDLE; otherwise frame_err for 1 cycle, discard byte, go IDLE.
REQ-019 Parity failure SHALL be reported only at the stop edge; the stop bit SHALL still be consumed.
REQ-020 Timeout counter: cleared on every edge and in IDLE; increments in other states; on reaching TIMEOUT -> IDLE, frame_err for 1 cycle, partial byte discarded.
REQ-021 Push latency: rx_valid and rd_data SHALL update on the clk edge after the stop-bit edge cycle.
REQ-022 rd_en with FIFO empty SHALL be ignored; rd_data remains 16'h0000.
REQ-023 rd_en with FIFO non-empty: rd_data shows the next entry (or 16'h0000) from the following cycle.
REQ-024 Push when full with no pop: byte dropped, rx_overflow <= 1, contents unchanged.
REQ-025 Push and pop in the same cycle when full: pop then push, both succeed, no overflow.
REQ-026 Push and pop in the same cycle when empty: push succeeds, pop ignored.
REQ-027 rx_overflow SHALL clear on any cycle with rd_en=1 and no new overflow in that cycle; new overflow wins.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy count SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-029 While rst=1: FSM=IDLE, bit count 0, timeout 0, FIFO empty, synchronizer flops 1, rx_valid=0, rx_overflow=0, frame_err=0, rd_data=16'h0000.
REQ-030 Reset mid-frame SHALL discard the partial frame with no frame_err.
REQ-031 After release, the first accepted start bit SHALL be a falling edge that occurs after release.

Verification
REQ-032 Send 0x1C frame (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> rx_valid=1, rd_data=16'h001C; rd_en -> rx_valid=0, rd_data=16'h0000.
REQ-033 Send 0xF0 with parity bit 0 -> single frame_err pulse at stop; rx_valid stays 0.
REQ-034 Send 0x11,0x22,0x33,0x44,0x55 with no reads, FIFO_DEPTH=4 -> rx_overflow=1; four reads return 0x0011,0x0022,0x0033,0x0044; first read clears rx_overflow.
REQ-035 Start bit + 3 data bits, then ps2_clk idle for TIMEOUT+10 cycles -> frame_err pulse; then a full 0x29 frame -> rd_data=16'h0029.
REQ-036 Assert rst after the 5th bit of a frame, release, send 0x5A -> only 0x005A received, frame_err never pulses.
REQ-037 FIFO full with rd_en asserted on the push cycle -> no overflow; order preserved; occupancy stays 4.
